// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Function codes match the ALU operation encoding. The package also holds the
// sequencer state type.
package muldiv_pkg;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem          in  WIDTH  partial remainder before this step
//   dividend_bit in  1      next dividend bit, shifted into the remainder
//   divisor      in  WIDTH  divisor magnitude
//   rem_next     out WIDTH  partial remainder after this step
//   q_bit        out 1      quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = (shifted >= {1'b0, divisor});
    // When the trial subtraction succeeds, the difference is below the
    // divisor, so it always fits in WIDTH bits.
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller that owns the HI/LO register pair.
// It sequences MULT/MULTU/DIV/DIVU and executes MTHI/MTLO.
// Configuration macro: MULDIV_ITERATIVE_MULT_EN. When it is defined, multiply
// runs shift-add over WIDTH cycles. When it is undefined, multiply takes one
// RUN cycle using '*'.
// Ports:
//   clk        in  1      clock, rising edge
//   reset      in  1      synchronous active-high reset
//   start      in  1      issue strobe
//   op         in  6      function code
//   operand_a  in  WIDTH  rs: multiplicand / dividend / MTHI-MTLO data
//   operand_b  in  WIDTH  rt: multiplier / divisor
//   busy       out 1      unit occupied
//   done       out 1      one-cycle pulse when HI/LO hold a new result
//   hi, lo     out WIDTH  architectural HI/LO registers
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;        // |dividend|, becomes the quotient; |multiplicand|
  logic [WIDTH-1:0]   b_q, b_d;        // |divisor| or |multiplier|
  logic [2*WIDTH-1:0] acc_q, acc_d;    // product, or remainder in the low half
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;          // negate product / quotient
  logic               rem_neg_q, rem_neg_d;  // remainder takes dividend sign
  logic               dbz_q, dbz_d;          // divide by zero

  logic               is_mul_op, is_div_op, is_signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef MULDIV_ITERATIVE_MULT_EN
  logic [WIDTH:0]     add_sum;
`else
  logic [2*WIDTH-1:0] ext_a, ext_b;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem          (acc_q[WIDTH-1:0]),
    .dividend_bit (a_q[WIDTH-1]),
    .divisor      (b_q),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  // Operand decode and magnitude extraction, used at issue.
  always_comb begin
    is_mul_op    = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg        = is_signed_op & operand_a[WIDTH-1];
    b_neg        = is_signed_op & operand_b[WIDTH-1];
    a_mag        = a_neg ? -operand_a : operand_a;
    b_mag        = b_neg ? -operand_b : operand_b;
  end

  // Sign fix-up applied in FIX.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    // Divide by zero leaves the quotient as all ones. The remainder equals
    // |dividend|, so restoring its sign returns the dividend as given.
    quot_fix = (neg_q && !dbz_q) ? -a_q : a_q;
    rem_fix  = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
`ifdef MULDIV_ITERATIVE_MULT_EN
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
`else
    ext_a     = {{WIDTH{1'b0}}, a_q};
    ext_b     = {{WIDTH{1'b0}}, b_q};
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_mul_op || is_div_op) begin
            a_d       = a_mag;
            b_d       = b_mag;
            acc_d     = '0;
            cnt_d     = '0;
            is_div_d  = is_div_op;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dbz_d     = (operand_b == '0);
            busy_d    = 1'b1;
            state_d   = StRun;
          end else if (op == OP_MTHI) begin
            hi_d = operand_a;
          end else if (op == OP_MTLO) begin
            lo_d = operand_a;
          end
        end
      end

      StRun: begin
        if (is_div_q) begin
          // The quotient shifts into a_q as the dividend bits shift out.
          a_d   = {a_q[WIDTH-2:0], step_q};
          acc_d = {{WIDTH{1'b0}}, step_rem};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_d = StFix;
          end
        end else begin
`ifdef MULDIV_ITERATIVE_MULT_EN
          // Right-shifting shift-add: the upper half accumulates, and
          // finished low bits move down into the lower half.
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_d = StFix;
          end
`else
          acc_d   = ext_a * ext_b;
          state_d = StFix;
`endif
        end
      end

      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer (WIDTH = 32). Stimulus pushes the
// expected HI/LO and busy length. A monitor pops and compares on each done
// pulse. Expected multiply latency follows MULDIV_ITERATIVE_MULT_EN.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
  localparam int DivBusy = W + 1;
`ifdef MULDIV_ITERATIVE_MULT_EN
  localparam int MulBusy = W + 1;
`else
  localparam int MulBusy = 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   op = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  muldiv_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   bcnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles and score every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          check({e.name, "_busy_cycles"}, 64'(bcnt), 64'(e.busy_cycles));
          check({e.name, "_busy_low_at_done"}, 64'(busy), 64'd0);
        end
        bcnt = 0;
      end
    end
  end

  // Callers are always at a negedge. Start is held across exactly one posedge.
  task automatic issue(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] h,
                               input logic [W-1:0] l, input int bc);
    exp_t e;
    e.name = name;
    e.hi = h;
    e.lo = l;
    e.busy_cycles = bc;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge where done is high.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [5:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] h, input logic [W-1:0] l,
                        input int bc);
    expect_result(name, h, l, bc);
    issue(o, a, b);
    wait_done(name);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);

    @(negedge clk);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DivBusy);
    @(negedge clk);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivBusy);
    @(negedge clk);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DivBusy);
    @(negedge clk);
    run_op("div_by0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DivBusy);
    @(negedge clk);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DivBusy);
    @(negedge clk);
    run_op("div_neg_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DivBusy);
    @(negedge clk);
    run_op("divu_max_10", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, DivBusy);
    @(negedge clk);
    run_op("mult_m1_2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulBusy);
    @(negedge clk);
    run_op("multu_m1_2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, MulBusy);
    @(negedge clk);
    run_op("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MulBusy);

    // MTHI / MTLO take effect one edge later, without busy.
    @(negedge clk);
    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_lo_kept", 64'(lo), 64'hFFFF_FFEB);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(OP_MTLO, 32'h0000_ABCD, 32'd0);
    check("mtlo_lo", 64'(lo), 64'hABCD);
    check("mtlo_hi_kept", 64'(hi), 64'h1234);

    // Illegal function code is ignored.
    issue(6'b100000, 32'hDEAD_BEEF, 32'd3);
    check("illegal_busy", 64'(busy), 64'd0);
    check("illegal_hi", 64'(hi), 64'h1234);
    check("illegal_lo", 64'(lo), 64'hABCD);

    // Start pulses during RUN are ignored.
    expect_result("divu_midrun", 32'd2, 32'd14, DivBusy);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    issue(OP_MTHI, 32'hDEAD, 32'd0);
    issue(OP_MULT, 32'd9, 32'd9);
    wait_done("divu_midrun");

    // Back-to-back issue in the done cycle.
    @(negedge clk);
    run_op("divu_1000_3", OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, DivBusy);
    expect_result("multu_b2b", 32'd0, 32'd15, MulBusy);
    issue(OP_MULTU, 32'd3, 32'd5);
    wait_done("multu_b2b");
    issue(OP_MTLO, 32'h55, 32'd0);
    check("mtlo_b2b_lo", 64'(lo), 64'h55);
    check("mtlo_b2b_hi", 64'(hi), 64'd0);
    check("mtlo_b2b_busy", 64'(busy), 64'd0);

    // Reset during a divide discards it.
    @(negedge clk);
    issue(OP_DIV, 32'd12345, 32'd7);
    repeat (9) @(negedge clk);
    d0 = n_done;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    repeat (40) @(negedge clk);
    check("rst_mid_no_done", 64'(n_done), 64'(d0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide controller that owns the architectural HI/LO register pair. It sequences MULT, MULTU, DIV and DIVU over several clocks and executes MTHI/MTLO. The pipeline issues an operation with a one-cycle start strobe and stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly. The combinational ALU no longer produces HI/LO results.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Must be even and ≥ 4. The iteration count equals `WIDTH`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: issue strobe, sampled on the rising edge of `clk`.
- `op`  in  6: function code. Legal values: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
- `operand_a`  in  WIDTH: rs value, the multiplicand or dividend.
- `operand_b`  in  WIDTH: rt value, the multiplier or divisor.
- `busy`  out  1: unit occupied; the pipeline must hold MULT/DIV/MFHI/MFLO/MTHI/MTLO issue while high.
- `done`  out  1: one-cycle pulse; HI/LO hold the new result in the same cycle.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- **States:** IDLE, RUN, FIX.
- **Reset:** state IDLE, iteration counter 0, `hi`=0, `lo`=0, `busy`=0, `done`=0. Reset wins over every other event, including mid-RUN or FIX. Any partial result is discarded; HI/LO are zeroed.
- **IDLE, `start`, MULT/MULTU/DIV/DIVU:**
  - Latch the magnitudes of both operands. Magnitude is two's-complement absolute value for signed ops and the raw value for unsigned ops.
  - Latch the result-sign flags; clear the accumulator.
  - Go to RUN.
- **IDLE, `start`, MTHI/MTLO:** `hi` or `lo` is loaded with `operand_a` at that edge. There is no `busy` and no `done`.
- **IDLE, `start`, any other `op`:** ignored; no state change.
- **`start` while not IDLE:** ignored; never queued.
- **RUN, divide:** one restoring step per cycle (shift the remainder, trial-subtract the divisor, set the quotient bit). `WIDTH` cycles, then FIX.
- **RUN, multiply:** see Configuration.
- **FIX:** one cycle. Apply signs, write HI/LO, pulse `done`, return to IDLE.
  - **Multiply:** {HI,LO} is the 2·WIDTH-bit product. For signed ops the product is negated when exactly one operand was negative.
  - **Divide:** LO is the quotient, HI the remainder. For DIV, the quotient is negated if the operand signs differ and the remainder takes the dividend's sign.
  - **Divide by zero:** not trapped. Result is LO = all ones and HI = the dividend as given, for both DIV and DIVU. This falls out of the restoring algorithm before sign fix; for signed divide-by-zero the sign fix is suppressed.
  - **Signed overflow:** DIV of most-negative by −1 gives LO = 100…0 and HI = 0.
- **Outside FIX and MTHI/MTLO:** `hi`/`lo` hold their value. During RUN they show the previous result.

## Timing
- Edge E0 samples `start`. RUN covers edges E1..E_WIDTH; FIX writes at edge E_WIDTH+1.
- `busy` is high from after E0 until after E_WIDTH+1. That is WIDTH+1 cycles, 33 for WIDTH=32.
- `done` is high exactly in the cycle following E_WIDTH+1, with `busy` already low.
- A new `start` is accepted in the same cycle that `done` is high (back-to-back issue).
- MTHI/MTLO take effect one edge after issue. They are accepted in the `done` cycle too.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- **`MULDIV_ITERATIVE_MULT_EN` defined:** multiply uses shift-add in RUN, one multiplier bit per cycle, `WIDTH` cycles. Latency is identical to divide.
- **Macro undefined:**
  - Multiply computes the full product with a single `*` operator in one RUN cycle; FIX follows at E2.
  - `busy` is high for 2 cycles and `done` appears after E2.
  - The divide path is unchanged.

## Structure
- Shared package `muldiv_pkg`:
  - Function-code localparams (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`, `OP_MTHI`, `OP_MTLO`), identical to the ALU operation encoding.
  - State enum (IDLE, RUN, FIX).
- Sub-module `div_step`: purely combinational single restoring-division iteration. Inputs are the remainder, the dividend bit and the divisor. Outputs are the next remainder and the quotient bit.
- The iterative multiplier step stays inline.

## Test plan
- **DIVU:** 100 / 7 → after 33 `busy` cycles, `done` pulses with `lo`=14, `hi`=2.
- **DIV:** −7 (FFFFFFF9) / 2 → `lo`=FFFFFFFD (−3), `hi`=FFFFFFFF (−1). Also 80000000 / FFFFFFFF → `lo`=80000000, `hi`=0.
- **DIV by zero:** 5 / 0 → `lo`=FFFFFFFF, `hi`=5, no hang.
- **MULT:** FFFFFFFF × 2 → {`hi`,`lo`} = FFFFFFFF_FFFFFFFE. MULTU same operands → `hi`=1, `lo`=FFFFFFFE.
  - Run with and without `MULDIV_ITERATIVE_MULT_EN`; check 33 vs 2 `busy` cycles.
- **Issue rules:**
  - MTHI 0x1234 → `hi`=0x1234 next cycle, `busy` stays 0.
  - `start` asserted mid-RUN → ignored; result equals the first op.
  - Second op issued in the `done` cycle → accepted.
- **Reset mid-operation:** `reset` at cycle 10 of a DIV → next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse.
